// File: rtl/fp_sched_pkg.sv
// Shared types and helpers for the round-robin compare-unit scheduler.
package fp_sched_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_NUM_REQ = 4;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_TAG_W = clog2_min1(DEF_NUM_REQ);

    typedef logic [DEF_TAG_W-1:0] tag_t;

endpackage

// File: rtl/fp_cmp_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester after ptr.
module rr_arbiter
    import fp_sched_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Offset N wraps back onto ptr itself, so the last grantee is lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_cmp_rr_scheduler.sv
// Shares one fixed-latency FP less-than unit among NUM_REQ requesters, round-robin,
// tagging each issue and routing the result back to its originator.
module fp_cmp_rr_scheduler
    import fp_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter  int unsigned DATA_W      = DEF_DATA_W,
    parameter  int unsigned CMP_LATENCY = 2,
    localparam int unsigned TAG_W       = clog2_min1(NUM_REQ),
    // Sized to hold CMP_LATENCY+2 outstanding operations.
    localparam int unsigned CNT_W       = $clog2(CMP_LATENCY + 3)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_value1,
    input  logic [NUM_REQ*DATA_W-1:0] req_value2,
    output logic [DATA_W-1:0]         cmp_value1,
    output logic [DATA_W-1:0]         cmp_value2,
    output logic                      cmp_issue,
    input  logic [DATA_W-1:0]         cmp_result,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [CNT_W-1:0]          in_flight
);

    logic [NUM_REQ-1:0]     grant;
    logic [TAG_W-1:0]       ptr_q;
    logic [TAG_W-1:0]       grant_idx;
    logic                   accept;
    logic                   rsp_any;
    logic [DATA_W-1:0]      sel_value1;
    logic [DATA_W-1:0]      sel_value2;
    logic [NUM_REQ-1:0]     rsp_valid_d;

    // cmp_issue plus issue_tag_q form the stage the unit samples from;
    // pipe_* then tracks the op for the CMP_LATENCY cycles the unit takes.
    logic [TAG_W-1:0]       issue_tag_q;
    logic [CMP_LATENCY-1:0] pipe_vld_q;
    logic [TAG_W-1:0]       pipe_tag_q [CMP_LATENCY];

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr_q),
        .grant(grant)
    );

    always_comb begin
        req_ready   = areset ? '0 : grant;
        accept      = |req_ready;
        rsp_any     = |rsp_valid;
        grant_idx   = '0;
        sel_value1  = '0;
        sel_value2  = '0;
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                grant_idx  = TAG_W'(i);
                sel_value1 = req_value1[i*DATA_W +: DATA_W];
                sel_value2 = req_value2[i*DATA_W +: DATA_W];
            end
            rsp_valid_d[i] = pipe_vld_q[CMP_LATENCY-1]
                             && (pipe_tag_q[CMP_LATENCY-1] == TAG_W'(i));
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cmp_value1  <= '0;
            cmp_value2  <= '0;
            cmp_issue   <= 1'b0;
            issue_tag_q <= '0;
            pipe_vld_q  <= '0;
            for (int unsigned k = 0; k < CMP_LATENCY; k++) begin
                pipe_tag_q[k] <= '0;
            end
            rsp_valid   <= '0;
            rsp_result  <= '0;
            in_flight   <= '0;
            ptr_q       <= TAG_W'(NUM_REQ - 1);
        end else begin
            cmp_issue   <= accept;
            issue_tag_q <= grant_idx;
            if (accept) begin
                cmp_value1 <= sel_value1;
                cmp_value2 <= sel_value2;
                ptr_q      <= grant_idx;
            end
            pipe_vld_q[0] <= cmp_issue;
            pipe_tag_q[0] <= issue_tag_q;
            for (int unsigned k = 1; k < CMP_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_tag_q[k] <= pipe_tag_q[k-1];
            end
            rsp_valid <= rsp_valid_d;
            if (pipe_vld_q[CMP_LATENCY-1]) begin
                rsp_result <= cmp_result;
            end
            in_flight <= in_flight + CNT_W'(accept) - CNT_W'(rsp_any);
        end
    end

endmodule
